// File: rtl/demux1to2_stream.sv
// demux1to2_stream: steers each input beat to one of two FIFO-buffered output channels by in_sel
module demux1to2_stream #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] full_n = (AW+1)'(DEPTH);
  logic [1:0] full, vld, push, pop, ordy;
  logic [1:0][DATA_W-1:0] dout;
  logic [1:0][CNT_W-1:0] cnt;
  assign ordy = {out1_ready, out0_ready};
  // ready looks only at the selected channel's full flag: head-of-line blocking, no out-ready path
  assign in_ready = ~full[in_sel];
  genvar g;
  for (g = 0; g < 2; g++) begin : ch
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] occ;
    assign full[g] = occ == full_n;
    assign vld[g]  = occ != '0;
    assign push[g] = in_valid & in_ready & (in_sel == 1'(g));
    assign pop[g]  = vld[g] & ordy[g];
    assign dout[g] = mem[rp];
    always_ff @(posedge clk)
      if (push[g]) mem[wp] <= in_data;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        wp     <= '0;
        rp     <= '0;
        occ    <= '0;
        cnt[g] <= '0;
      end else begin
        wp     <= push[g] ? wp + 1'b1 : wp;
        rp     <= pop[g] ? rp + 1'b1 : rp;
        occ    <= occ + (AW+1)'(push[g]) - (AW+1)'(pop[g]);
        cnt[g] <= push[g] ? cnt[g] + 1'b1 : cnt[g];
      end
  end
  assign out0_valid = vld[0];
  assign out1_valid = vld[1];
  assign out0_data  = dout[0];
  assign out1_data  = dout[1];
  assign cnt0       = cnt[0];
  assign cnt1       = cnt[1];
endmodule

// File: doc/demux1to2_stream.md
Name: demux1to2_stream

Overview:
Stream-side counterpart of the 2:1 selector. It takes one valid/ready input stream and steers each beat to one of two output channels according to a per-beat select bit. Each output channel has its own small FIFO, so a stalled consumer on one channel never drops data. It sits between a single producer and two independent consumers in the pr-series datapath. Per-channel beat counters are provided for debug and bench checking.

Parameters:
DATA_W, 8, width of data in and out
DEPTH, 2, entries per output FIFO; power of two, at least 2
CNT_W, 8, width of the per-channel accepted-beat counters

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat present
in_ready  output  1  block accepts the input beat this cycle
in_data  input  DATA_W  input payload
in_sel  input  1  destination of the beat: 0 = channel 0, 1 = channel 1
out0_valid  output  1  channel 0 head entry valid
out0_ready  input  1  channel 0 consumer accepts
out0_data  output  DATA_W  channel 0 head payload
out1_valid  output  1  channel 1 head entry valid
out1_ready  input  1  channel 1 consumer accepts
out1_data  output  DATA_W  channel 1 head payload
cnt0  output  CNT_W  beats accepted into channel 0
cnt1  output  CNT_W  beats accepted into channel 1

Behaviour:
- Reset: one clock, clk; rst_n is asynchronous and active-low. Asserting rst_n = 0 immediately clears both FIFOs (pointers and occupancy), out0_valid = out1_valid = 0, and cnt0 = cnt1 = 0. out*_data are don't-care while out*_valid = 0. Reset mid-transfer discards all buffered beats. Release is synchronous to clk.
- Handshake: a transfer occurs on a rising clk edge when valid && ready. in_data and in_sel must remain stable while in_valid = 1 and in_ready = 0. Out-side rules are the same: out*_data stays stable while out*_valid = 1 and the consumer has not accepted.
- in_ready is combinational: when in_sel = 0, it is the inverse of "FIFO0 full"; when in_sel = 1, it is the inverse of "FIFO1 full". It does not depend on in_valid.
- Head-of-line blocking is intended: a beat whose destination is full stalls the input even if the other channel has space. Beats are never reordered within a channel.
- A push occurs on an input transfer, into FIFO[in_sel]. A pop occurs on outN_valid && outN_ready.
- Latency: a beat pushed into an empty FIFO at edge k appears at outN_valid/outN_data after edge k. There is no combinational in-to-out path.
- Full FIFO with a simultaneous pop: in_ready is still 0 for that channel. There is no pass-through when full, which keeps ready free of out*_ready paths.
- Push and pop on the same FIFO in the same cycle, when not full and not empty: occupancy is unchanged and both pointers advance.
- Push into one channel while the other pops is fully independent.
- Pointers wrap modulo DEPTH. Occupancy is tracked with a count, or with an extra pointer bit, so that full and empty can be told apart.
- cntN increments by 1 on each push into FIFO N. It wraps modulo 2^CNT_W (255 -> 0 at the default width) and is not affected by pops.
- outN_valid = 1 exactly when FIFO N occupancy > 0. outN_data = FIFO N head entry.

Test Plan:
- Reset check: hold rst_n = 0 with in_valid = 1 and clk running -> out0_valid = out1_valid = 0, cnt0 = cnt1 = 0, and no push occurs. Release, then send 0xA5 with sel = 0 -> out0_valid = 1 with 0xA5 one edge later, cnt0 = 1.
- Steering and order: with both readies = 1, send 0x11/s0, 0x22/s1, 0x33/s0, 0x44/s1 back-to-back -> out0 delivers 0x11 then 0x33, out1 delivers 0x22 then 0x44, in_ready stays 1 throughout, cnt0 = cnt1 = 2.
- Full and blocking: out0_ready = 0, then send 0x01, 0x02, 0x03 all with sel = 0 -> after 2 beats in_ready = 0 and 0x03 is held. Switching in_sel to 1 is not allowed while stalled. Raising out0_ready for one cycle -> 0x01 pops, 0x03 is accepted on the following edge, and the FIFO then holds 0x02, 0x03.
- Full plus simultaneous pop: FIFO1 full (0x10, 0x20) and out1_ready = 1 with in_valid/sel = 1 -> in_ready = 0 that cycle, 0x10 pops, and the new beat is accepted the next cycle.
- Counter wrap: push 256 beats into channel 1 with out1_ready = 1 -> cnt1 = 0 and cnt0 is unchanged.
- Reset mid-operation: both FIFOs hold data and rst_n is pulsed low between edges -> out0_valid and out1_valid drop immediately, and no stale data appears after release.
